// File: rtl/spi_bus_scheduler.sv
// spi_bus_scheduler: arbitrates the shared analog-front-end SPI bus between the preamp, ADC and DAC engines.
// The preamp is reloaded after reset and on gain changes; ADC samples fire on a fixed tick; DAC writes fill the gaps.
module spi_bus_scheduler #(
    parameter int SAMPLE_DIV = 2500,
    parameter int GUARD = 4,
    parameter int TIMEOUT = 255,
    parameter logic [7:0] GAIN_RST = 8'h11
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] gain_in,
    input  logic       gain_wr,
    input  logic       dac_req,
    output logic       amp_start,
    output logic [7:0] amp_gain,
    input  logic       amp_done,
    output logic       adc_start,
    input  logic       adc_done,
    output logic       dac_start,
    input  logic       dac_done,
    output logic       dac_ack,
    output logic [1:0] bus_sel,
    output logic       spi_ss_b,
    output logic       fpga_init_b,
    output logic       busy,
    output logic       overrun,
    output logic       timeout_err
);
    localparam int TW = $clog2(SAMPLE_DIV);
    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {IDLE, AMP, ADC, DAC, GUARD_WAIT} state_t;

    state_t state, next;
    logic [TW-1:0] tick_cnt;
    logic [CW-1:0] cnt;
    logic [7:0] gain_hold;
    logic amp_pend, adc_pend, tick, in_grant, granted_done, timeout_hit;

    assign tick = tick_cnt == TW'(SAMPLE_DIV - 1);
    assign amp_start = state == AMP && cnt == '0;
    assign adc_start = state == ADC && cnt == '0;
    assign dac_start = state == DAC && cnt == '0;
    assign dac_ack = dac_start;
    assign bus_sel = state == AMP ? 2'd1 : state == ADC ? 2'd2 : state == DAC ? 2'd3 : 2'd0;
    assign busy = state != IDLE;
    assign spi_ss_b = 1'b1;
    assign fpga_init_b = 1'b1;

    always_comb begin
        in_grant = state == AMP || state == ADC || state == DAC;
        granted_done = (state == AMP && amp_done) || (state == ADC && adc_done) || (state == DAC && dac_done);
        timeout_hit = in_grant && !granted_done && cnt == CW'(TIMEOUT - 1);
        next = state;
        if (state == IDLE)
            next = amp_pend ? AMP : adc_pend ? ADC : dac_req ? DAC : IDLE;
        else if (in_grant && (granted_done || timeout_hit))
            next = GUARD_WAIT;
        else if (state == GUARD_WAIT && cnt == CW'(GUARD - 1))
            next = IDLE;
    end

    // Set requests (tick, gain_wr, amp abort) override the clear-on-grant in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt <= '0;
            tick_cnt <= '0;
            amp_pend <= 1'b1;
            adc_pend <= 1'b0;
            gain_hold <= GAIN_RST;
            amp_gain <= GAIN_RST;
            overrun <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            state <= next;
            cnt <= next != state ? '0 : cnt + 1'b1;
            tick_cnt <= tick ? '0 : tick_cnt + 1'b1;
            amp_pend <= gain_wr || (timeout_hit && state == AMP) || (amp_pend && state != IDLE);
            adc_pend <= tick || (adc_pend && !(state == IDLE && !amp_pend));
            if (gain_wr) gain_hold <= gain_in;
            if (state == IDLE && amp_pend) amp_gain <= gain_hold;
            overrun <= overrun || (tick && adc_pend);
            timeout_err <= timeout_err || timeout_hit;
        end
    end
endmodule

// File: tb/tb_spi_bus_scheduler.sv
// tb_spi_bus_scheduler: randomized engines plus a transaction-level model predicting every start pulse
// (kind, cycle, gain); a monitor pops predictions whenever the DUT issues a start.
module tb_spi_bus_scheduler;
    localparam int DIV = 40;
    localparam int GUARD = 4;
    localparam int TMO = 255;

    logic clk = 0, rst = 1;
    logic [7:0] gain_in = 0;
    logic gain_wr = 0, dac_req = 0, amp_done = 0, adc_done = 0, dac_done = 0;
    logic amp_start, adc_start, dac_start, dac_ack, spi_ss_b, fpga_init_b, busy, overrun, timeout_err;
    logic [7:0] amp_gain;
    logic [1:0] bus_sel;

    always #5 clk = ~clk;

    spi_bus_scheduler #(.SAMPLE_DIV(DIV), .GUARD(GUARD), .TIMEOUT(TMO), .GAIN_RST(8'h11)) dut (
        .clk(clk), .rst(rst), .gain_in(gain_in), .gain_wr(gain_wr), .dac_req(dac_req),
        .amp_start(amp_start), .amp_gain(amp_gain), .amp_done(amp_done),
        .adc_start(adc_start), .adc_done(adc_done), .dac_start(dac_start), .dac_done(dac_done),
        .dac_ack(dac_ack), .bus_sel(bus_sel), .spi_ss_b(spi_ss_b), .fpga_init_b(fpga_init_b),
        .busy(busy), .overrun(overrun), .timeout_err(timeout_err)
    );

    typedef struct {int kind; int gain; int cyc;} exp_t;
    exp_t exp_q[$];
    int total = 0, bad = 0;

    task automatic chk(input string name, input int got, input int want);
        total++;
        if (got != want) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, got, want, $time);
        end
    endtask

    // Reference model: cycle numbers count clock edges since reset release.
    int cyc = 0, free_at = 1, m_kind = 0, m_s = 0;
    bit m_amp = 1, m_adc = 0, m_over = 0, m_tmo = 0, adc_before, kdone, tick;
    logic [7:0] m_hold = 8'h11;

    initial forever begin
        @(posedge clk);
        if (rst) begin
            cyc = 0; free_at = 1; m_kind = 0; m_amp = 1; m_adc = 0;
            m_over = 0; m_tmo = 0; m_hold = 8'h11;
            exp_q.delete();
        end else begin
            cyc++;
            adc_before = m_adc;
            kdone = (m_kind == 1 && amp_done) || (m_kind == 2 && adc_done) || (m_kind == 3 && dac_done);
            if (m_kind != 0) begin
                if (kdone || cyc == m_s + TMO) begin
                    if (!kdone) begin
                        m_tmo = 1;
                        if (m_kind == 1) m_amp = 1;
                    end
                    free_at = cyc + GUARD + 1;
                    m_kind = 0;
                end
            end else if (cyc == free_at) begin
                if (m_amp) begin
                    exp_q.push_back('{1, int'(m_hold), cyc}); m_amp = 0; m_kind = 1;
                end else if (m_adc) begin
                    exp_q.push_back('{2, 0, cyc}); m_adc = 0; m_kind = 2;
                end else if (dac_req) begin
                    exp_q.push_back('{3, 0, cyc}); m_kind = 3;
                end else
                    free_at = cyc + 1;
                m_s = cyc;
            end
            tick = cyc % DIV == 0;
            if (tick && adc_before) m_over = 1;
            if (tick) m_adc = 1;
            if (gain_wr) begin
                m_hold = gain_in;
                m_amp = 1;
            end
        end
    end

    // Monitor: every start pulse must match the oldest prediction.
    int got_kind;
    exp_t e;
    initial forever begin
        @(negedge clk);
        if (!rst) begin
            if (exp_q.size() != 0 && exp_q[0].cyc < cyc) begin
                chk("missing_start", 0, exp_q[0].kind);
                void'(exp_q.pop_front());
            end
            if (amp_start || adc_start || dac_start) begin
                got_kind = {dac_start, adc_start, amp_start} == 3'b001 ? 1 :
                           {dac_start, adc_start, amp_start} == 3'b010 ? 2 :
                           {dac_start, adc_start, amp_start} == 3'b100 ? 3 : 7;
                if (exp_q.size() == 0)
                    chk("unexpected_start", got_kind, 0);
                else begin
                    e = exp_q.pop_front();
                    chk("start_kind", got_kind, e.kind);
                    chk("start_cycle", cyc, e.cyc);
                    chk("bus_sel", int'(bus_sel), e.kind);
                    chk("busy", int'(busy), 1);
                    chk("dac_ack", int'(dac_ack), int'(e.kind == 3));
                    if (e.kind == 1) chk("amp_gain", int'(amp_gain), e.gain);
                end
            end
        end
    end

    // Engines: each answers done a chosen number of cycles after its start; -2 means never.
    int due_amp = -1, due_adc = -1, due_dac = -1;
    int lat_fix = 10, adc_ovr = -1, dac_ovr = -1, dac_rate = 0;

    function automatic int lat();
        return lat_fix >= 0 ? lat_fix : int'($urandom_range(0, 12));
    endfunction

    task automatic step();
        @(negedge clk);
        gain_wr = 0;
        if (rst) begin
            due_amp = -1; due_adc = -1; due_dac = -1;
        end else begin
            if (amp_start) due_amp = cyc + lat();
            if (adc_start) begin
                due_adc = adc_ovr == -2 ? -1 : cyc + (adc_ovr >= 0 ? adc_ovr : lat());
                adc_ovr = -1;
            end
            if (dac_start) begin
                due_dac = cyc + (dac_ovr >= 0 ? dac_ovr : lat());
                dac_ovr = -1;
            end
        end
        amp_done = cyc == due_amp;
        adc_done = cyc == due_adc;
        dac_done = cyc == due_dac;
        if (dac_ack) dac_req = 0;
        else if (!dac_req && int'($urandom_range(0, 99)) < dac_rate) dac_req = 1;
    endtask

    task automatic wait_bus(input int k, input int n);
        for (int i = 0; i < n && int'(bus_sel) != k; i++) step();
        chk("wait_bus", int'(bus_sel), k);
    endtask

    initial begin
        repeat (3) step();
        chk("rst_bus_sel", int'(bus_sel), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_pulses", int'({amp_start, adc_start, dac_start, dac_ack}), 0);
        chk("rst_spi_ss_b", int'(spi_ss_b), 1);
        chk("rst_fpga_init_b", int'(fpga_init_b), 1);
        chk("rst_amp_gain", int'(amp_gain), 8'h11);
        chk("rst_overrun", int'(overrun), 0);
        chk("rst_timeout", int'(timeout_err), 0);
        rst = 0;
        repeat (100) step();
        wait_bus(2, 100);
        repeat (3) step();
        gain_in = 8'h22;
        gain_wr = 1;
        repeat (80) step();
        chk("gain_reload", int'(amp_gain), 8'h22);
        lat_fix = -1;
        dac_rate = 100;
        repeat (600) step();
        dac_rate = 30;
        for (int i = 0; i < 1500; i++) begin
            step();
            if ($urandom_range(0, 63) == 0) begin
                gain_in = 8'($urandom);
                gain_wr = 1;
            end
        end
        chk("overrun_steady", int'(overrun), 0);
        dac_rate = 0;
        repeat (60) step();
        adc_ovr = -2;
        repeat (2 * DIV + TMO + 20) step();
        chk("timeout_err", int'(timeout_err), 1);
        chk("timeout_model", int'(timeout_err), int'(m_tmo));
        chk("overrun_model4", int'(overrun), int'(m_over));
        rst = 1;
        repeat (2) step();
        rst = 0;
        dac_ovr = 100;
        dac_req = 1;
        repeat (300) step();
        chk("overrun", int'(overrun), 1);
        chk("overrun_model", int'(overrun), int'(m_over));
        chk("timeout_clear", int'(timeout_err), int'(m_tmo));
        lat_fix = 30;
        dac_req = 1;
        wait_bus(3, 200);
        repeat (5) step();
        rst = 1;
        step();
        chk("midrst_bus_sel", int'(bus_sel), 0);
        chk("midrst_busy", int'(busy), 0);
        rst = 0;
        repeat (200) step();
        chk("final_overrun", int'(overrun), int'(m_over));
        chk("final_timeout", int'(timeout_err), int'(m_tmo));
        chk("queue_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
